// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   OSR           oversample ratio: s_tick pulses per bit period
//   uart_state_e  receiver FSM state encoding
package uart_pkg;

    localparam int unsigned OSR = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit. Resets to 1 (idle line).
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   d        asynchronous input
//   q        synchronized output
module uart_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, optional parity, configurable stop length.
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   s_tick        one-clk pulse at 16x baud rate
//   rx            asynchronous serial line, idle high
//   dout          last received data word (LSB received first)
//   rx_done_tick  one-clk pulse when dout / frame_err / parity_err update
//   frame_err     stop bit sampled low in the last frame
//   parity_err    parity mismatch in the last frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int unsigned CW = (SB_TICK > OSR) ? 5 : 4;
    localparam logic [CW-1:0] MidStart = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] BitEnd   = CW'(OSR - 1);
    localparam logic [CW-1:0] StopEnd  = CW'(SB_TICK - 1);
    localparam logic [2:0]    LastBit  = 3'(DBIT - 1);
    localparam logic          ParEn    = (PARITY_EN != 0);
    localparam logic          ParOdd   = (PARITY_ODD != 0);

    logic rx_s;

    uart_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    uart_state_e     state_q, state_d;
    logic [CW-1:0]   s_cnt_q, s_cnt_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            pbit_q, pbit_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    // Set once the line has been seen high; a frame may only start on a fall
    // after that, so a held-low (break) line cannot retrigger.
    logic            armed_q, armed_d;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        pbit_d  = pbit_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        armed_d = armed_q | rx_s;

        case (state_q)
            StIdle: begin
                if (!rx_s && armed_q) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_cnt_q == MidStart) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;  // glitch, not a start bit
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_cnt_q == BitEnd) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_q == LastBit) begin
                            state_d = ParEn ? StParity : StStop;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (s_tick) begin
                    if (s_cnt_q == BitEnd) begin
                        s_cnt_d = '0;
                        pbit_d  = rx_s;
                        state_d = StStop;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_cnt_q == StopEnd) begin
                        state_d = StIdle;
                        dout_d  = shreg_q;
                        ferr_d  = ~rx_s;
                        perr_d  = ParEn & (^shreg_q ^ pbit_q ^ ParOdd);
                        done_d  = 1'b1;
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            pbit_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            armed_q <= armed_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 8N1 instance and one 8E1 (even parity) instance,
// directed frames plus random frames, checked against a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam bit B_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       rx_a, rx_b;
    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b, fe_a, fe_b, pe_a, pe_b;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int unsigned n_checks   = 0;
    int unsigned n_errors   = 0;
    int unsigned done_cnt_a = 0;
    int unsigned done_cnt_b = 0;

    uart_rx u_dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx_a),
        .dout         (dout_a),
        .rx_done_tick (done_a),
        .frame_err    (fe_a),
        .parity_err   (pe_a)
    );

    uart_rx #(
        .DBIT       (8),
        .SB_TICK    (16),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx_b),
        .dout         (dout_b),
        .rx_done_tick (done_b),
        .frame_err    (fe_b),
        .parity_err   (pe_b)
    );

    always #5 clk = ~clk;

    // s_tick: one clk high every 4 clk, changed on the falling edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: data as sent, frame error iff stop bit low,
    // parity error iff the count of ones over data+parity has the wrong sense.
    function automatic exp_t model(input logic [7:0] d, input bit par_en, input bit pbit,
                                   input bit stop);
        exp_t e;
        int   ones;
        ones = $countones(d) + int'(pbit);
        e.d  = d;
        e.fe = !stop;
        e.pe = par_en && ((ones % 2) != (B_ODD ? 1 : 0));
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1) begin
                done_cnt_a++;
                if (q_a.size() == 0) begin
                    check_eq("a_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check_eq("a_dout", {24'd0, dout_a}, {24'd0, e.d});
                    check_eq("a_frame_err", {31'd0, fe_a}, {31'd0, e.fe});
                    check_eq("a_parity_err", {31'd0, pe_a}, {31'd0, e.pe});
                end
            end
            if (done_b === 1'b1) begin
                done_cnt_b++;
                if (q_b.size() == 0) begin
                    check_eq("b_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check_eq("b_dout", {24'd0, dout_b}, {24'd0, e.d});
                    check_eq("b_frame_err", {31'd0, fe_b}, {31'd0, e.fe});
                    check_eq("b_parity_err", {31'd0, pe_b}, {31'd0, e.pe});
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input bit sel, input bit val, input int ticks);
        @(negedge clk);
        if (sel) rx_b = val;
        else     rx_a = val;
        wait_ticks(ticks);
    endtask

    task automatic idle(input bit sel, input int bits);
        drive_bit(sel, 1'b1, 16 * bits);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit pbit, input bit stop);
        if (sel) q_b.push_back(model(d, 1'b1, pbit, stop));
        else     q_a.push_back(model(d, 1'b0, 1'b0, stop));
        drive_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 16);
        if (sel) drive_bit(sel, pbit, 16);
        drive_bit(sel, stop, 16);
    endtask

    initial begin
        logic [7:0]  d;
        bit          stop;
        bit          pb;
        int unsigned cnt;

        reset_n = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_dout", {24'd0, dout_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_ferr", {31'd0, fe_a}, 32'd0);
        check_eq("rst_perr", {31'd0, pe_b}, 32'd0);
        reset_n = 1'b1;
        idle(0, 2);

        // Single 8N1 frame.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        idle(0, 1);
        check_eq("a5_done_cnt", done_cnt_a, 32'd1);

        // Back-to-back, no idle gap.
        send_frame(0, 8'h00, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        idle(0, 1);
        check_eq("b2b_done_cnt", done_cnt_a, 32'd3);

        // Start-bit glitch: 3 ticks low.
        drive_bit(0, 1'b0, 3);
        idle(0, 2);
        check_eq("glitch_done_cnt", done_cnt_a, 32'd3);
        check_eq("glitch_idle", {29'd0, u_dut_a.state_q}, {29'd0, StIdle});

        // Bad stop bit then good frame.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        idle(0, 1);
        send_frame(0, 8'h41, 1'b0, 1'b1);
        idle(0, 1);
        check_eq("ferr_done_cnt", done_cnt_a, 32'd5);

        // Break: line held low for 25 bit times yields a single frame.
        q_a.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
        drive_bit(0, 1'b0, 16 * 25);
        check_eq("break_done_cnt", done_cnt_a, 32'd6);
        check_eq("break_idle", {29'd0, u_dut_a.state_q}, {29'd0, StIdle});
        idle(0, 2);
        send_frame(0, 8'h96, 1'b0, 1'b1);
        idle(0, 1);
        check_eq("post_break_cnt", done_cnt_a, 32'd7);

        // Even parity.
        send_frame(1, 8'h07, 1'b0, 1'b1);
        idle(1, 1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        idle(1, 1);
        check_eq("par_done_cnt", done_cnt_b, 32'd2);

        // Reset mid-frame, during data bit 4.
        drive_bit(0, 1'b0, 16);
        d = 8'hC3;
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], 16);
        drive_bit(0, d[4], 8);
        @(negedge clk);
        reset_n = 1'b0;
        rx_a    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_dout", {24'd0, dout_a}, 32'd0);
        check_eq("mid_rst_ferr", {31'd0, fe_a}, 32'd0);
        check_eq("mid_rst_perr_b", {31'd0, pe_b}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done_a}, 32'd0);
        reset_n = 1'b1;
        idle(0, 2);
        check_eq("mid_rst_cnt", done_cnt_a, 32'd7);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        idle(0, 1);
        check_eq("post_rst_cnt", done_cnt_a, 32'd8);

        // Random frames on both instances.
        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(0, d, 1'b0, stop);
            if (!stop || $urandom_range(0, 1) == 1) idle(0, 1);
        end
        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            pb   = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(1, d, pb, stop);
            if (!stop || $urandom_range(0, 1) == 1) idle(1, 1);
        end
        idle(0, 2);
        idle(1, 2);

        cnt = done_cnt_a;
        check_eq("rand_a_cnt", cnt, 32'd18);
        check_eq("rand_b_cnt", done_cnt_b, 32'd12);
        check_eq("drain_a", q_a.size(), 32'd0);
        check_eq("drain_b", q_b.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, oversample ticks spanning the stop bit (16 = 1 stop bit, 32 = 2).
REQ-003 SHALL have parameter PARITY_EN, default 0, where 1 means a parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd parity (used only when PARITY_EN = 1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-006 clk  input  1  system clock (100 MHz nominal).
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 s_tick  input  1  one-clk pulse at 16x baud rate from the baud generator.
REQ-009 rx  input  1  asynchronous serial line, idle high.
REQ-010 dout  output  DBIT  last received data word, LSB received first.
REQ-011 rx_done_tick  output  1  one-clk pulse when dout, frame_err and parity_err are updated.
REQ-012 frame_err  output  1  stop bit sampled low in the last frame.
REQ-013 parity_err  output  1  parity mismatch in the last frame (always 0 when PARITY_EN = 0).

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only, which adds 2 clk of latency.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a 4-bit tick counter s_cnt (5-bit if SB_TICK > 16) and a 3-bit bit counter n.
REQ-016 IDLE: when rx_s = 0, go to START and set s_cnt = 0; s_tick is not required for this transition.
REQ-017 START: on s_tick with s_cnt = 7 (mid start bit), go to DATA and clear s_cnt and n if rx_s = 0; otherwise treat it as a glitch and return to IDLE with no outputs changed. On s_tick with s_cnt < 7, increment s_cnt.
REQ-018 DATA: on s_tick with s_cnt = 15, shift right (shreg <= {rx_s, shreg[DBIT-1:1]}) and clear s_cnt. Then go to PARITY if n = DBIT-1 and PARITY_EN = 1, go to STOP if n = DBIT-1 and PARITY_EN = 0, otherwise increment n.
REQ-019 PARITY: on s_tick with s_cnt = 15, latch the parity bit, clear s_cnt and go to STOP.
REQ-020 STOP: on s_tick with s_cnt = SB_TICK-1, go to IDLE and in the same clk:
- load dout from shreg
- set frame_err = ~rx_s
- set parity_err = PARITY_EN & (^shreg ^ pbit ^ PARITY_ODD)
- pulse rx_done_tick for exactly one clk
REQ-021 s_cnt SHALL advance only on clk edges where s_tick = 1; it never wraps silently, because each state clears it at its terminal count.
REQ-022 dout, frame_err and parity_err SHALL hold their values between frames and change only on rx_done_tick.
REQ-023 A frame with frame_err = 1 SHALL still assert rx_done_tick and update dout.
REQ-024 A line held low (break) SHALL yield dout = 0 with frame_err = 1, then stay in IDLE until rx_s returns to 1 and falls again; a low line seen on entry to IDLE SHALL NOT start a new frame.
REQ-025 s_tick pulses in IDLE SHALL be ignored.

Reset
REQ-026 On reset_n low, asynchronously and regardless of mid-frame state:
- state = IDLE
- s_cnt, n, shreg, dout, frame_err, parity_err and rx_done_tick = 0
- synchronizer flops = 1 (idle line)
REQ-027 A frame in progress at reset SHALL be discarded without asserting rx_done_tick.

Structure
REQ-028 Package uart_pkg SHALL hold the state encoding (3-bit enum) and the oversample constant OSR = 16, shared with the transmitter.
REQ-029 The synchronizer SHALL be the sub-module uart_sync2, with ports clk, reset_n, d and q, and reset value 1.

Verification
REQ-030 Bench: s_tick every 4 clk, 8N1, rx sends 0xA5 -> one rx_done_tick, dout = 0xA5, frame_err = 0, parity_err = 0.
REQ-031 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses, dout = 0x00 then 0xFF.
REQ-032 Start-bit glitch of 3 ticks low then high -> no rx_done_tick, FSM back in IDLE.
REQ-033 Frame 0x3C with stop bit driven low -> dout = 0x3C, frame_err = 1; a following 0x41 with a good stop bit -> frame_err = 0.
REQ-034 PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 -> parity_err = 1; with parity bit 1 -> parity_err = 0.
REQ-035 reset_n pulsed low during DATA bit 4 -> no rx_done_tick, outputs 0; the next clean frame 0x5A is received correctly.
